// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK counter sequencer: FSM state encoding,
// the JK excitation op codes and the single-cell next-state rule.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Op codes are the {J,K} pair applied to one cell.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jkNext(input logic [1:0] op, input logic qCur);
        logic result;
        result = qCur;
        case (op)
            JK_RST:  result = 1'b0;
            JK_SET:  result = 1'b1;
            JK_TGL:  result = ~qCur;
            default: result = qCur;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/jk_count_ctrl_if.sv
// Command/status bundle between control logic and the JK counter sequencer.
interface jk_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] len;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             hold;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_bus;
    logic [WIDTH-1:0] k_bus;
    logic             busy;
    logic             wrap;
    logic             done;

    modport master (
        output start, len, dir, load, load_val, hold,
        input  q, j_bus, k_bus, busy, wrap, done
    );

    modport slave (
        input  start, len, dir, load, load_val, hold,
        output q, j_bus, k_bus, busy, wrap, done
    );
endinterface

// File: rtl/jk_cell.sv
// One JK flip-flop with synchronous active-low reset; the counter bank is
// built from these so every bit change goes through its J/K pair.
module jk_cell
    import jk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= jkNext({j, k}, q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_count_ctrl.sv
// Sequencer for a bank of JK cells run as a programmable mod-MOD up/down
// counter: accepts load/start commands and drives per-bit J/K excitation.
module jk_count_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic clk,
    input  logic reset,
    jk_count_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD);

    state_t           state_q;
    logic [WIDTH-1:0] remain_q;
    logic             runDir_q;
    logic             wrap_q;
    logic             done_q;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] jBus;
    logic [WIDTH-1:0] kBus;
    logic             stepFires;
    logic             stepWraps;

    function automatic logic [WIDTH-1:0] satLoad(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] result;
        result = v;
        if ({1'b0, v} >= MOD_W) begin
            result = MAX_VAL;
        end
        return result;
    endfunction

    // Target value for the bank; held equal to the present value whenever
    // nothing should move so the excitation collapses to J=K=0.
    always_comb begin
        count_d   = count;
        stepFires = 1'b0;
        stepWraps = 1'b0;
        if (reset) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        count_d = satLoad(bus.load_val);
                    end
                end
                S_RUN: begin
                    if (!bus.hold) begin
                        stepFires = 1'b1;
                        if (runDir_q) begin
                            if (count == MAX_VAL) begin
                                count_d   = '0;
                                stepWraps = 1'b1;
                            end else begin
                                count_d = count + WIDTH'(1);
                            end
                        end else begin
                            if (count == '0) begin
                                count_d   = MAX_VAL;
                                stepWraps = 1'b1;
                            end else begin
                                count_d = count - WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    count_d = count;
                end
            endcase
        end
    end

    assign jBus = ~count & count_d;
    assign kBus = count & ~count_d;

    // Control FSM; done is raised on the same edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            runDir_q <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wrap_q <= stepWraps;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.load) begin
                        if (bus.len != '0) begin
                            remain_q <= bus.len;
                            runDir_q <= bus.dir;
                            state_q  <= S_RUN;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stepFires) begin
                        remain_q <= remain_q - WIDTH'(1);
                        if (remain_q == WIDTH'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (jBus[i]),
            .k     (kBus[i]),
            .q     (count[i])
        );
    end

    assign bus.q     = count;
    assign bus.j_bus = jBus;
    assign bus.k_bus = kBus;
    assign bus.busy  = (state_q == S_RUN);
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Scoreboard bench for jk_count_ctrl: a behavioural counter model predicts
// each cycle's outputs, and a monitor compares them after every edge.
module tb_jk_count_ctrl;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic clk;
    logic reset;

    jk_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

    jk_count_ctrl #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int q;
        bit busy;
        bit wrap;
        bit done;
        int j;
        int k;
    } exp_t;

    exp_t expQueue[$];
    int   checks = 0;
    int   errors = 0;

    int refQ     = 0;
    int refLeft  = 0;
    int refPhase = PH_IDLE;
    bit refDir   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and push the model's prediction for the edge.
    task automatic applyStimulus(input bit rstN, input bit st, input int ln, input bit dr,
                                 input bit ld, input int lv, input bit hd);
        exp_t e;
        int   nq;
        bit   w;
        bit   d;
        @(negedge clk);
        reset        = rstN;
        bus.start    = st;
        bus.len      = WIDTH'(ln);
        bus.dir      = dr;
        bus.load     = ld;
        bus.load_val = WIDTH'(lv);
        bus.hold     = hd;
        nq = refQ;
        w  = 1'b0;
        d  = 1'b0;
        if (!rstN) begin
            nq       = 0;
            refPhase = PH_IDLE;
            refLeft  = 0;
            refDir   = 1'b0;
        end else begin
            case (refPhase)
                PH_IDLE: begin
                    if (ld) begin
                        nq = (lv >= MOD) ? MOD - 1 : lv;
                    end else if (st) begin
                        if (ln != 0) begin
                            refLeft  = ln;
                            refDir   = dr;
                            refPhase = PH_RUN;
                        end else begin
                            refPhase = PH_DONE;
                            d        = 1'b1;
                        end
                    end
                end
                PH_RUN: begin
                    if (!hd) begin
                        if (refDir) begin
                            nq = (refQ + 1) % MOD;
                            w  = (refQ == MOD - 1);
                        end else begin
                            nq = (refQ + MOD - 1) % MOD;
                            w  = (refQ == 0);
                        end
                        refLeft--;
                        if (refLeft == 0) begin
                            refPhase = PH_DONE;
                            d        = 1'b1;
                        end
                    end
                end
                default: refPhase = PH_IDLE;
            endcase
        end
        e.q    = nq;
        e.busy = (refPhase == PH_RUN);
        e.wrap = w;
        e.done = d;
        e.j    = rstN ? ((~refQ & nq) & MASK) : 0;
        e.k    = rstN ? ((refQ & ~nq) & MASK) : 0;
        refQ   = nq;
        expQueue.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    // Monitor: grab excitation before the edge, compare outputs after it.
    initial begin
        exp_t             e;
        logic [WIDTH-1:0] jS;
        logic [WIDTH-1:0] kS;
        logic [WIDTH-1:0] qPre;
        logic [WIDTH-1:0] qRule;
        logic             rS;
        forever begin
            @(negedge clk);
            #2;
            jS   = bus.j_bus;
            kS   = bus.k_bus;
            qPre = bus.q;
            rS   = reset;
            @(posedge clk);
            #1;
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                checkOutput("q", int'(bus.q), e.q);
                checkOutput("busy", int'(bus.busy), int'(e.busy));
                checkOutput("wrap", int'(bus.wrap), int'(e.wrap));
                checkOutput("done", int'(bus.done), int'(e.done));
                checkOutput("j_bus", int'(jS), e.j);
                checkOutput("k_bus", int'(kS), e.k);
                if (rS) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (jS[i] && kS[i])      qRule[i] = ~qPre[i];
                        else if (jS[i])          qRule[i] = 1'b1;
                        else if (kS[i])          qRule[i] = 1'b0;
                        else                     qRule[i] = qPre[i];
                    end
                    checkOutput("jk_rule", int'(bus.q), int'(qRule));
                end
            end
        end
    end

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.hold     = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5, 1'b1, 1'b1, 7, 1'b0);

        $display("[TB] load and saturation");
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 12, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 1'b1, 1'b1, 5, 1'b0);
        idleCycles(2);

        $display("[TB] count up with wrap");
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0);
        applyStimulus(1'b1, 1'b1, 5, 1'b1, 1'b0, 0, 1'b0);
        idleCycles(7);

        $display("[TB] count down with hold");
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        idleCycles(4);

        $display("[TB] zero length and ignored starts");
        applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 4, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2, 1'b0, 1'b1, 9, 1'b0);
        applyStimulus(1'b1, 1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
        idleCycles(5);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0);
        applyStimulus(1'b1, 1'b1, 5, 1'b1, 1'b0, 0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        idleCycles(3);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            bit rstN;
            bit st;
            bit ld;
            bit hd;
            rstN = ($urandom_range(0, 99) >= 2);
            st   = ($urandom_range(0, 99) < 35);
            ld   = ($urandom_range(0, 99) < 15);
            hd   = ($urandom_range(0, 99) < 25);
            applyStimulus(rstN, st, int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)),
                          ld, int'($urandom_range(0, MASK)), hd);
        end

        repeat (2) @(posedge clk);
        #3;
        checkOutput("queue_drained", expQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
